// File: rtl/serial_addsub_if.sv
// Start/done handshake bundle for the digit-serial adder/subtractor.
// Master drives the request and operands; slave returns status and result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   z;
    logic             ovf;

    modport master (output start, op, x, y, input busy, done, z, ovf);
    modport slave  (input start, op, x, y, output busy, done, z, ovf);
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement add/sub: CHUNK bits per clock, LSB first,
// returning the exact sign-extended WIDTH+1-bit result and a WIDTH-bit overflow flag.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one chunk per clock, N clocks total
// DONE  | result valid for one cycle; start here chains the next operation
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic            clk,
    input  logic            rst,
    serial_addsub_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH:0]   z_q;
    logic             ovf_q;

    logic [CHUNK-1:0] a_chk;
    logic [CHUNK-1:0] b_chk;
    logic [CHUNK-1:0] s_chk;
    logic             cout;
    logic             cin_msb;
    logic [WIDTH-1:0] sum_next;

    always_comb begin
        a_chk = a_q[cnt*CHUNK +: CHUNK];
        b_chk = b_q[cnt*CHUNK +: CHUNK];
        {cout, s_chk} = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit recovered from its sum bit; only meaningful on the last chunk.
        cin_msb  = a_chk[CHUNK-1] ^ b_chk[CHUNK-1] ^ s_chk[CHUNK-1];
        sum_next = sum_q;
        sum_next[cnt*CHUNK +: CHUNK] = s_chk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.x;
                        b_q     <= bus.op ? ~bus.y : bus.y;
                        carry_q <= bus.op;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_q   <= sum_next;
                    carry_q <= cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        z_q    <= {a_chk[CHUNK-1] ^ b_chk[CHUNK-1] ^ cout, sum_next};
                        ovf_q  <= cin_msb ^ cout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.z    = z_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: an 8-bit/2-bit-chunk instance and a
// 16-bit single-chunk instance, with hand-computed expected results.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    serial_addsub_if #(.WIDTH(8))  b8();
    serial_addsub_if #(.WIDTH(16)) b16();

    serial_addsub #(.WIDTH(8),  .CHUNK(2))  dut8  (.clk(clk), .rst(rst), .bus(b8));
    serial_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    always #5 clk = ~clk;

    // Drives one 8-bit operation and waits (bounded) for done; lat = -1 on timeout.
    task automatic do_op8(input logic o, input logic [7:0] a, input logic [7:0] b,
                          output logic [8:0] zo, output logic vo, output int lat, output int bc);
        b8.op = o; b8.x = a; b8.y = b; b8.start = 1'b1;
        @(posedge clk); #1;
        b8.start = 1'b0; b8.x = ~a; b8.y = ~b; b8.op = ~o;
        bc  = b8.busy ? 1 : 0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (b8.busy) bc++;
            if (b8.done) begin
                lat = i;
                break;
            end
        end
        zo = b8.z;
        vo = b8.ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b8.start = 1'b0; b8.op = 1'b0; b8.x = '0; b8.y = '0;
        b16.start = 1'b0; b16.op = 1'b0; b16.x = '0; b16.y = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (b8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", b8.busy); end
        total++; if (b8.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", b8.done); end
        total++; if (b8.z !== 9'h000) begin bad++; $display("FAIL reset_z got %h want 000", b8.z); end
        total++; if (b8.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", b8.ovf); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        logic [8:0] zo; logic vo; int lat; int bc;
        do_op8(1'b0, 8'h08, 8'hFB, zo, vo, lat, bc);
        total++; if (lat !== 4) begin bad++; $display("FAIL add_basic_latency got %0d want 4", lat); end
        total++; if (bc !== 4) begin bad++; $display("FAIL add_basic_busy_cycles got %0d want 4", bc); end
        total++; if (zo !== 9'h003) begin bad++; $display("FAIL add_basic_z got %h want 003", zo); end
        total++; if (vo !== 1'b0) begin bad++; $display("FAIL add_basic_ovf got %b want 0", vo); end
    endtask

    task automatic test_add_edges();
        logic [8:0] zo; logic vo; int lat; int bc;
        do_op8(1'b0, 8'hFF, 8'hFF, zo, vo, lat, bc);
        total++; if (zo !== 9'h1FE || vo !== 1'b0)
            begin bad++; $display("FAIL add_m1_m1 got z=%h ovf=%b want z=1fe ovf=0", zo, vo); end
        do_op8(1'b0, 8'h80, 8'hFF, zo, vo, lat, bc);
        total++; if (zo !== 9'h17F || vo !== 1'b1)
            begin bad++; $display("FAIL add_neg_ovf got z=%h ovf=%b want z=17f ovf=1", zo, vo); end
        do_op8(1'b0, 8'h7F, 8'h01, zo, vo, lat, bc);
        total++; if (zo !== 9'h080 || vo !== 1'b1)
            begin bad++; $display("FAIL add_pos_ovf got z=%h ovf=%b want z=080 ovf=1", zo, vo); end
    endtask

    task automatic test_sub();
        logic [8:0] zo; logic vo; int lat; int bc;
        do_op8(1'b1, 8'hC0, 8'hE0, zo, vo, lat, bc);
        total++; if (zo !== 9'h1E0 || vo !== 1'b0)
            begin bad++; $display("FAIL sub_basic got z=%h ovf=%b want z=1e0 ovf=0", zo, vo); end
        total++; if (lat !== 4) begin bad++; $display("FAIL sub_latency got %0d want 4", lat); end
        do_op8(1'b1, 8'h80, 8'h80, zo, vo, lat, bc);
        total++; if (zo !== 9'h000 || vo !== 1'b0)
            begin bad++; $display("FAIL sub_min_min got z=%h ovf=%b want z=000 ovf=0", zo, vo); end
    endtask

    // start held high, operands changing every cycle: only k = 0, 5, 10 are accepted.
    task automatic test_back_to_back();
        int ndone = 0;
        for (int k = 0; k < 15; k++) begin
            b8.start = 1'b1;
            b8.x  = 8'(k * 3 + 1);
            b8.y  = 8'(k * 5 + 2);
            b8.op = k[0];
            @(posedge clk); #1;
            if (b8.done) ndone++;
            if (k == 4) begin
                total++; if (b8.done !== 1'b1 || b8.z !== 9'h003 || b8.ovf !== 1'b0)
                    begin bad++; $display("FAIL b2b_first got done=%b z=%h ovf=%b want 1 003 0", b8.done, b8.z, b8.ovf); end
            end
            if (k == 7) begin
                total++; if (b8.z !== 9'h003 || b8.busy !== 1'b1)
                    begin bad++; $display("FAIL b2b_hold_during_run got z=%h busy=%b want 003 1", b8.z, b8.busy); end
            end
            if (k == 9) begin
                total++; if (b8.done !== 1'b1 || b8.z !== 9'h1F5 || b8.ovf !== 1'b0)
                    begin bad++; $display("FAIL b2b_second got done=%b z=%h ovf=%b want 1 1f5 0", b8.done, b8.z, b8.ovf); end
            end
            if (k == 14) begin
                total++; if (b8.done !== 1'b1 || b8.z !== 9'h053 || b8.ovf !== 1'b0)
                    begin bad++; $display("FAIL b2b_third got done=%b z=%h ovf=%b want 1 053 0", b8.done, b8.z, b8.ovf); end
            end
        end
        b8.start = 1'b0;
        total++; if (ndone !== 3) begin bad++; $display("FAIL b2b_done_count got %0d want 3", ndone); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] zo; logic vo; int lat; int bc; int ndone = 0;
        b8.op = 1'b0; b8.x = 8'h10; b8.y = 8'h20; b8.start = 1'b1;
        @(posedge clk); #1;
        b8.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (b8.busy !== 1'b0 || b8.done !== 1'b0 || b8.z !== 9'h000 || b8.ovf !== 1'b0)
            begin bad++; $display("FAIL abort_outputs got busy=%b done=%b z=%h ovf=%b want 0 0 000 0", b8.busy, b8.done, b8.z, b8.ovf); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (b8.done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_no_done got %0d pulses want 0", ndone); end
        do_op8(1'b0, 8'h10, 8'h20, zo, vo, lat, bc);
        total++; if (zo !== 9'h030 || vo !== 1'b0 || lat !== 4)
            begin bad++; $display("FAIL after_abort got z=%h ovf=%b lat=%0d want 030 0 4", zo, vo, lat); end
    endtask

    task automatic test_single_chunk();
        b16.op = 1'b0; b16.x = 16'h7FFF; b16.y = 16'h0001; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0; b16.x = 16'h0000; b16.y = 16'h0000;
        total++; if (b16.busy !== 1'b1 || b16.done !== 1'b0)
            begin bad++; $display("FAIL n1_run got busy=%b done=%b want 1 0", b16.busy, b16.done); end
        @(posedge clk); #1;
        total++; if (b16.done !== 1'b1 || b16.busy !== 1'b0)
            begin bad++; $display("FAIL n1_done got done=%b busy=%b want 1 0", b16.done, b16.busy); end
        total++; if (b16.z !== 17'h08000 || b16.ovf !== 1'b1)
            begin bad++; $display("FAIL n1_result got z=%h ovf=%b want 08000 1", b16.z, b16.ovf); end
        @(posedge clk); #1;
        total++; if (b16.done !== 1'b0)
            begin bad++; $display("FAIL n1_done_pulse got %b want 0", b16.done); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_edges();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        test_single_chunk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised, digit-serial two's-complement adder/subtractor for the ALU datapath. It processes CHUNK bits per clock from LSB to MSB, using a start/done handshake. It returns a sign-extended WIDTH+1-bit result plus a signed-overflow flag for the WIDTH-bit result. It is the multi-cycle, width-generic successor of the 8-bit combinational add/sub. It trades latency for area at large WIDTH.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2.
CHUNK, 2, bits processed per cycle; must satisfy 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0.
(Derived) N = WIDTH/CHUNK, the number of RUN cycles.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request to begin an operation; sampled only when not busy.
op  input  1  0 = x + y, 1 = x - y.
x  input  WIDTH  operand A, two's complement.
y  input  WIDTH  operand B, two's complement.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse: z and ovf are valid and updated.
z  output  WIDTH+1  exact signed result, sign-extended to WIDTH+1 bits.
ovf  output  1  1 when the true result does not fit in signed WIDTH bits.

Behaviour:
- Clocking and reset:
  - Single clock, clk. Reset is synchronous and active-high on rst.
  - On reset: state = IDLE, busy = 0, done = 0, z = 0, ovf = 0, chunk counter = 0, carry = 0.
  - Reset wins over every other input on the same edge.
  - Reset mid-RUN aborts the operation: no done pulse, and the outputs clear.
- State machine states: IDLE, RUN, DONE.
  - IDLE: busy = 0. If start = 1 at an edge:
    - latch x, y, op into operand registers;
    - load carry = op;
    - load effective B = op ? ~y : y;
    - set counter = 0 and go to RUN.
  - RUN: busy = 1. Each edge adds chunk [counter*CHUNK +: CHUNK] of A and effective B plus carry.
    - Write the sum chunk into the result shift register and update carry.
    - Increment counter.
    - On the edge that processes chunk N-1, go to DONE. In the same edge:
      - z = {sign, sum[WIDTH-1:0]}, where sign = A[W-1] ^ Beff[W-1] ^ carry-out;
      - ovf = carry into MSB ^ carry out of MSB;
      - done = 1.
  - DONE: done = 1 for exactly this one cycle. busy = 0.
    - start = 1 at this edge is accepted exactly as in IDLE, giving back-to-back operation.
    - Otherwise go to IDLE.
- Handshake and output rules:
  - start while busy = 1 is ignored; the operands in flight are unaffected.
  - x, y and op may change freely after the accepting edge.
  - Latency: start is sampled at edge T0, and done is high in the cycle following edge T0+N. Throughput is one result per N+1 cycles.
  - z and ovf hold their last value until the next done or reset. They do not change during RUN.
- Arithmetic:
  - z always equals the mathematically exact x ± y in WIDTH+1 signed bits; it never wraps.
  - Subtraction is x + ~y + 1.
  - The -2^(W-1) - (-2^(W-1)) case yields 0 with ovf = 0.
- CHUNK = WIDTH (N = 1): one RUN cycle. The same handshake applies, with no special-casing visible at the ports.

Test Plan:
- WIDTH=8, CHUNK=2, op=0, x=8'h08, y=8'hFB (8 + -5) -> done exactly 4 cycles after the start edge; z=9'h003, ovf=0; busy high for 4 cycles.
- op=0, x=8'hFF, y=8'hFF -> z=9'h1FE, ovf=0. Then x=8'h80, y=8'hFF -> z=9'h17F (-129), ovf=1. Then x=8'h7F, y=8'h01 -> z=9'h080 (+128), ovf=1.
- op=1, x=8'hC0, y=8'hE0 (-64 - -32) -> z=9'h1E0, ovf=0. op=1, x=8'h80, y=8'h80 -> z=9'h000, ovf=0.
- Hold start=1 continuously with operands changed every cycle -> only the values latched at the IDLE/DONE edges are used; a result arrives every 5 cycles; mid-RUN operands are ignored.
- Assert rst for 1 cycle in the 2nd RUN cycle -> no done pulse; busy=0, z=0, ovf=0 on the next cycle; a new start then completes normally.
- WIDTH=16, CHUNK=16, op=0, x=16'h7FFF, y=16'h0001 -> done 1 cycle after start; z=17'h08000, ovf=1.
